// File: rtl/goldschmidt_sqrt_seq.sv
// Sequential Goldschmidt square root / reciprocal square root in signed fixed point.
// Result valid 2+2*ITERS cycles after accept (1 cycle for invalid operands); holds in DONE until out_ready.
module goldschmidt_sqrt_seq #(
    parameter int INT_BITS  = 16,
    parameter int FRAC_BITS = 16,
    parameter int ITERS     = 3
) (
    input  logic                                  clk,
    input  logic                                  resetn,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [INT_BITS+FRAC_BITS-1:0]  in_data,
    input  logic signed [INT_BITS+FRAC_BITS-1:0]  in_est,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic signed [INT_BITS+FRAC_BITS-1:0]  out_rsqrt,
    output logic signed [INT_BITS+FRAC_BITS-1:0]  out_sqrt,
    output logic                                  out_err
);

    localparam int W  = INT_BITS + FRAC_BITS;
    localparam int CW = $clog2(ITERS + 1);

    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [W-1:0] HALF = {{(W-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, INIT, CALC_R, UPDATE, DONE} state_t;

    state_t                state_q, state_d;
    logic signed [W-1:0]   s_q, s_d, y_q, y_d;
    logic signed [W-1:0]   x_q, x_d, h_q, h_d, r_q, r_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic signed [W-1:0]   sqrt_q, sqrt_d, rsqrt_q, rsqrt_d;
    logic                  err_q, err_d;
    logic                  op_ok;
    logic                  last_iter;

    function automatic logic signed [W-1:0] sat_mul(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [2*W-1:0] ae;
        logic signed [2*W-1:0] be;
        logic signed [2*W-1:0] p;
        logic [W:0]            top;
        ae  = a;
        be  = b;
        p   = (ae * be) >>> FRAC_BITS;
        top = p[2*W-1:W-1];
        if (top != {(W+1){1'b0}} && top != {(W+1){1'b1}})
            return p[2*W-1] ? MINV : MAXV;
        return p[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] sat_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1])
            return s[W] ? MINV : MAXV;
        return s[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [W:0] s;
        s = {a[W-1], a} - {b[W-1], b};
        if (s[W] != s[W-1])
            return s[W] ? MINV : MAXV;
        return s[W-1:0];
    endfunction

    // Both operands must be strictly positive for the iteration to converge.
    assign op_ok     = !in_data[W-1] && (in_data != '0) && !in_est[W-1] && (in_est != '0);
    assign last_iter = (cnt_q == CW'(ITERS - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = op_ok ? INIT : DONE;
            INIT:    state_d = CALC_R;
            CALC_R:  state_d = UPDATE;
            UPDATE:  state_d = last_iter ? DONE : CALC_R;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        s_d     = s_q;
        y_d     = y_q;
        x_d     = x_q;
        h_d     = h_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        sqrt_d  = sqrt_q;
        rsqrt_d = rsqrt_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    s_d   = in_data;
                    y_d   = in_est;
                    cnt_d = '0;
                    if (!op_ok) begin
                        sqrt_d  = '0;
                        rsqrt_d = MAXV;
                        err_d   = 1'b1;
                    end
                end
            end
            INIT: begin
                x_d = sat_mul(s_q, y_q);
                h_d = y_q >>> 1;
            end
            CALC_R: r_d = sat_sub(HALF, sat_mul(x_q, h_q));
            UPDATE: begin
                x_d   = sat_add(x_q, sat_mul(x_q, r_q));
                h_d   = sat_add(h_q, sat_mul(h_q, r_q));
                cnt_d = cnt_q + CW'(1);
                if (last_iter) begin
                    sqrt_d  = x_d;
                    rsqrt_d = sat_add(h_d, h_d);
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_q     <= '0;
            y_q     <= '0;
            x_q     <= '0;
            h_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            sqrt_q  <= '0;
            rsqrt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            y_q     <= y_d;
            x_q     <= x_d;
            h_q     <= h_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            sqrt_q  <= sqrt_d;
            rsqrt_q <= rsqrt_d;
            err_q   <= err_d;
        end
    end

    assign out_sqrt  = sqrt_q;
    assign out_rsqrt = rsqrt_q;
    assign out_err   = err_q;

endmodule

// File: doc/goldschmidt_sqrt_seq.md
GOLDSCHMIDT_SQRT_SEQ -- requirements
Module: goldschmidt_sqrt_seq

Interface
REQ-001 SHALL have parameter INT_BITS, default 16: signed integer bits, including sign, of the fixed-point format.
REQ-002 SHALL have parameter FRAC_BITS, default 16: fraction bits; W = INT_BITS+FRAC_BITS.
REQ-003 SHALL have parameter ITERS, default 3, range 1..8: number of Goldschmidt iterations.
REQ-004 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: operand offered.
REQ-007 SHALL have port in_ready, output, 1: unit can accept an operand.
REQ-008 SHALL have port in_data, input, W: radicand S, signed fixed-point.
REQ-009 SHALL have port in_est, input, W: initial 1/sqrt(S) estimate y0, signed fixed-point.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-012 SHALL have port out_rsqrt, output, W: 1/sqrt(S).
REQ-013 SHALL have port out_sqrt, output, W: sqrt(S).
REQ-014 SHALL have port out_err, output, 1: invalid operand flag.

Function
REQ-015 SHALL use FSM states IDLE, INIT, CALC_R, UPDATE, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL accept an operand on the rising edge where in_valid && in_ready; this is cycle T. S and y0 SHALL be registered at that edge.
REQ-017 SHALL go IDLE->INIT on accept when S>0 and y0>0; INIT computes x=S*y0 and h=y0/2 (arithmetic shift right by 1).
REQ-018 SHALL in CALC_R compute r = 0.5 - x*h; in UPDATE compute x = x + x*r and h = h + h*r using the r value from CALC_R; UPDATE->CALC_R until ITERS iterations have completed, then UPDATE->DONE.
REQ-019 SHALL assert out_valid first in cycle T+2+2*ITERS (T+8 at ITERS=3), with out_sqrt = x, out_rsqrt = 2*h (saturated), and out_err = 0.
REQ-020 SHALL form every product as the full 2W-bit signed product, arithmetic-shifted right by FRAC_BITS (truncation toward -inf), then saturated to the W-bit signed range; additions SHALL saturate likewise.
REQ-021 SHALL, if S<=0 or y0<=0 at accept, go IDLE->DONE directly (out_valid in T+1), with out_err=1, out_sqrt=0 and out_rsqrt=max positive (0x7FFF_FFFF for W=32).
REQ-022 SHALL hold out_valid, out_sqrt, out_rsqrt and out_err stable in DONE while out_ready=0; DONE->IDLE on the edge where out_ready=1.
REQ-023 SHALL keep in_ready=0 in every state except IDLE, so there is no accept in the same cycle as result retirement; in_valid outside IDLE SHALL be ignored.
REQ-024 SHALL hold out_sqrt, out_rsqrt and out_err at their last values after retirement, until the next DONE entry.
REQ-025 SHALL use an iteration counter of width clog2(ITERS+1), cleared at accept.

Reset
REQ-026 SHALL, while resetn=0, force state=IDLE, out_valid=0, out_sqrt=0, out_rsqrt=0, out_err=0, counter=0, and x, h and r to 0; in_ready=1.
REQ-027 SHALL, on assertion of resetn=0 mid-computation or in DONE, abort immediately with no out_valid pulse; after release the unit SHALL accept a new operand normally.

Verification
REQ-028 SHALL check, default params: in_data=0x00040000 (4.0), in_est=0x00008000 (0.5) -> at T+8 out_valid=1, out_sqrt=0x00020000, out_rsqrt=0x00008000, out_err=0.
REQ-029 SHALL check: in_data=0x00020000 (2.0), in_est=0x0000B333 (0.7) -> at T+8 out_sqrt=0x00016A0A ±4 LSB, out_rsqrt=0x0000B505 ±4 LSB.
REQ-030 SHALL check: in_data=0xFFFF0000 (-1.0) or in_est=0 -> out_valid at T+1, out_err=1, out_sqrt=0, out_rsqrt=0x7FFFFFFF.
REQ-031 SHALL check: out_ready held 0 for 5 cycles after out_valid -> outputs stable and in_ready=0 throughout; retirement on the first out_ready=1 edge, then in_ready=1.
REQ-032 SHALL check: resetn pulsed low at T+4 -> no out_valid; all outputs 0; the next operand completes correctly at its own T+8.
REQ-033 SHALL check, INT_BITS=8, FRAC_BITS=8, ITERS=1: in_data=0x0400, in_est=0x0080 -> at T+4 out_sqrt=0x0200, out_rsqrt=0x0080.
